cpu_run_monitor: RTL and testbench
==================================

// Module: cpu_run_monitor
// PURPOSE
//  Downstream observer for the single-cycle CPU. Samples the CPU PC every cycle and
//  declares the program finished when the PC self-loops for STABLE_CYCLES consecutive
//  cycles, or when a cycle timeout expires. It then reads DUMP_WORDS words from the data
//  memory read port and streams them out over valid/ready for checking or UART dump.
// PARAMETERS
//  STABLE_CYCLES   10    consecutive equal-PC samples that count as halt (>=1)
//  TIMEOUT_CYCLES  1000  max RUN cycles before a forced stop (>=STABLE_CYCLES)
//  DUMP_WORDS      10    words to dump (1..256)
//  DUMP_BASE       0     first dmem word index to dump
//  AW              8     dmem word-address width
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  reset        in   1   reset, synchronous, active-low
//  run_en       in   1   level; 1 = monitor/dump, 0 = return to/stay in IDLE
//  pc_i         in   32  CPU program counter, sampled every cycle in RUN
//  dmem_raddr   out  AW  dmem word read address; sync read, data next cycle
//  dmem_rdata   in   32  dmem read data
//  out_valid    out  1   out_data/out_index/out_last valid
//  out_ready    in   1   consumer accepts the word when out_valid & out_ready
//  out_data     out  32  dumped word
//  out_index    out  8   word number 0..DUMP_WORDS-1
//  out_last     out  1   asserted with the final word
//  busy         out  1   state is RUN, READ, WAIT or OUT
//  done         out  1   dump complete, held in DONE
//  timed_out    out  1   run ended by timeout, not by halt
//  halt_pc      out  32  PC at halt detection (0 on timeout)
//  cycle_count  out  32  RUN cycles elapsed, saturating at 2^32-1
// BEHAVIOUR
//  Reset (reset==0 at an edge): state IDLE; all outputs 0 except dmem_raddr=DUMP_BASE.
//   Reset mid-run or mid-dump aborts immediately; an un-accepted word is dropped.
//  FSM: IDLE, RUN, READ, WAIT, OUT, DONE.
//  IDLE: run_en=1 -> RUN. Clear cycle_count, stable, idx, done, timed_out, halt_pc.
//   Set prev_pc=32'hFFFF_FFFF.
//  RUN, every cycle: cycle_count++; stable = (pc_i==prev_pc) ? stable+1 : 0; prev_pc=pc_i.
//   Halt: the updated stable reaches STABLE_CYCLES -> halt_pc=pc_i, go to READ.
//   Otherwise, if cycle_count reaches TIMEOUT_CYCLES -> timed_out=1, go to READ.
//   Halt and timeout in the same cycle: halt wins, timed_out stays 0.
//  READ: dmem_raddr=DUMP_BASE+idx (mod 2^AW), go to WAIT.
//  WAIT: out_data=dmem_rdata, out_index=idx, out_last=(idx==DUMP_WORDS-1), out_valid=1,
//   go to OUT. Read-to-valid latency is 2 cycles.
//  OUT: hold all out_* stable while out_ready=0.
//   On handshake: out_valid=0; if out_last go to DONE, else idx++ and go to READ.
//   Peak throughput is 1 word per 3 cycles.
//  DONE: done=1; busy=0; halt_pc, timed_out and cycle_count are held.
//   run_en=0 -> IDLE (clears done). A re-run needs a run_en 0->1 cycle.
//  run_en=0 in RUN, READ, WAIT or OUT: abort to IDLE next edge. out_valid drops even
//   without a handshake; this is the only allowed valid retraction.
//  An address wrap of DUMP_BASE+idx past 2^AW-1 is legal and wraps to 0.
// TESTING
//  1 pc_i 0,4,..,100, then 104 constant; dmem[0..9]=1,1,2,3,5,8,13,21,34,55; out_ready=1
//    -> halt_pc=104, timed_out=0, 10 words in order, out_last on index 9, done=1.
//  2 Same as test 1, with out_ready toggled pseudo-randomly
//    -> no word lost or duplicated; out_* stable while stalled.
//  3 pc_i increments forever, TIMEOUT_CYCLES=50
//    -> timed_out=1, halt_pc=0, cycle_count=50, full dump still produced.
//  4 Halt and timeout in the same cycle (PC constant from the start, TIMEOUT_CYCLES=10)
//    -> timed_out=0, halt_pc=PC.
//  5 reset=0 while OUT is stalled on index 4
//    -> next cycle IDLE, all outputs 0; a rerun dumps from index 0.
//  6 run_en dropped during RUN; also PC changing at stable=9 of 10
//    -> return to IDLE; stable restarts and halt needs 10 fresh equal samples.

Source files
------------

// File: rtl/cpu_run_monitor.sv
`default_nettype none
// cpu_run_monitor: detects CPU halt (PC self-loop) or run timeout, then streams a dmem window out.
// Revision 1.0 - initial release
module cpu_run_monitor #(
  parameter int STABLE_CYCLES  = 10,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int DUMP_WORDS     = 10,
  parameter int DUMP_BASE      = 0,
  parameter int AW             = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run_en,
  input  logic [31:0]   pc_i,
  output logic [AW-1:0] dmem_raddr,
  input  logic [31:0]   dmem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [7:0]    out_index,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          timed_out,
  output logic [31:0]   halt_pc,
  output logic [31:0]   cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_READ = 3'd2,
    S_WAIT = 3'd3,
    S_OUT  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [AW-1:0] c_base_addr   = AW'(DUMP_BASE);
  localparam logic [7:0]    c_last_idx    = 8'(DUMP_WORDS - 1);
  localparam logic [31:0]   c_stable_lim  = 32'(STABLE_CYCLES);
  localparam logic [31:0]   c_timeout_lim = 32'(TIMEOUT_CYCLES);

  state_t        state_q, state_d;
  logic [31:0]   prev_pc_q, prev_pc_d;
  logic [31:0]   stable_q, stable_d;
  logic [31:0]   cycle_q, cycle_d;
  logic [7:0]    idx_q, idx_d;
  logic          done_q, done_d;
  logic          timed_out_q, timed_out_d;
  logic [31:0]   halt_pc_q, halt_pc_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic          valid_q, valid_d;
  logic [31:0]   data_q, data_d;
  logic          last_q, last_d;

  assign busy = (state_q == S_RUN) || (state_q == S_READ) ||
                (state_q == S_WAIT) || (state_q == S_OUT);

  always_comb begin
    state_d     = state_q;
    prev_pc_d   = prev_pc_q;
    stable_d    = stable_q;
    cycle_d     = cycle_q;
    idx_d       = idx_q;
    done_d      = done_q;
    timed_out_d = timed_out_q;
    halt_pc_d   = halt_pc_q;
    raddr_d     = raddr_q;
    valid_d     = valid_q;
    data_d      = data_q;
    last_d      = last_q;
    if (!run_en && busy) begin
      // Abort is the only path that may retract out_valid without a handshake.
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cycle_d     = '0;
          stable_d    = '0;
          idx_d       = '0;
          done_d      = 1'b0;
          timed_out_d = 1'b0;
          halt_pc_d   = '0;
          prev_pc_d   = '1;
          raddr_d     = c_base_addr;
          valid_d     = 1'b0;
          data_d      = '0;
          last_d      = 1'b0;
          if (run_en) state_d = S_RUN;
        end
        S_RUN: begin
          cycle_d   = (cycle_q == '1) ? cycle_q : cycle_q + 32'd1;
          stable_d  = (pc_i == prev_pc_q) ? stable_q + 32'd1 : '0;
          prev_pc_d = pc_i;
          // Halt is tested first so a simultaneous timeout is not reported.
          if (stable_d >= c_stable_lim) begin
            halt_pc_d = pc_i;
            raddr_d   = c_base_addr + AW'(idx_q);
            state_d   = S_READ;
          end else if (cycle_d >= c_timeout_lim) begin
            timed_out_d = 1'b1;
            raddr_d     = c_base_addr + AW'(idx_q);
            state_d     = S_READ;
          end
        end
        S_READ: state_d = S_WAIT;
        S_WAIT: begin
          data_d  = dmem_rdata;
          last_d  = (idx_q == c_last_idx);
          valid_d = 1'b1;
          state_d = S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            valid_d = 1'b0;
            if (last_q) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + 8'd1;
              raddr_d = c_base_addr + AW'(idx_q + 8'd1);
              state_d = S_READ;
            end
          end
        end
        S_DONE: begin
          if (!run_en) begin
            done_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      prev_pc_q   <= '1;
      stable_q    <= '0;
      cycle_q     <= '0;
      idx_q       <= '0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
      halt_pc_q   <= '0;
      raddr_q     <= c_base_addr;
      valid_q     <= 1'b0;
      data_q      <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_pc_q   <= prev_pc_d;
      stable_q    <= stable_d;
      cycle_q     <= cycle_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
      timed_out_q <= timed_out_d;
      halt_pc_q   <= halt_pc_d;
      raddr_q     <= raddr_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      last_q      <= last_d;
    end
  end

  assign dmem_raddr  = raddr_q;
  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_index   = idx_q;
  assign out_last    = last_q;
  assign done        = done_q;
  assign timed_out   = timed_out_q;
  assign halt_pc     = halt_pc_q;
  assign cycle_count = cycle_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_monitor.sv
`default_nettype none
// tb_cpu_run_monitor: directed halt/timeout/abort scenarios with a scoreboarded dump stream.
module tb_cpu_run_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = '0;
  logic        out_ready = 1'b0;
  logic        run_m = 1'b0, run_t = 1'b0, run_h = 1'b0;
  logic [31:0] mem [256];
  logic [31:0] fib [10];
  int          total = 0;
  int          bad = 0;

  logic [7:0]  m_raddr, t_raddr, h_raddr;
  logic [31:0] m_rdata, t_rdata, h_rdata;
  logic        m_valid, t_valid, h_valid;
  logic [31:0] m_data, t_data, h_data;
  logic [7:0]  m_index, t_index, h_index;
  logic        m_last, t_last, h_last;
  logic        m_busy, t_busy, h_busy;
  logic        m_done, t_done, h_done;
  logic        m_to, t_to, h_to;
  logic [31:0] m_hpc, t_hpc, h_hpc;
  logic [31:0] m_cc, t_cc, h_cc;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    m_rdata <= mem[m_raddr];
    t_rdata <= mem[t_raddr];
    h_rdata <= mem[h_raddr];
  end

  cpu_run_monitor u_main (
    .clk(clk), .reset(reset), .run_en(run_m), .pc_i(pc),
    .dmem_raddr(m_raddr), .dmem_rdata(m_rdata),
    .out_valid(m_valid), .out_ready(out_ready), .out_data(m_data),
    .out_index(m_index), .out_last(m_last), .busy(m_busy), .done(m_done),
    .timed_out(m_to), .halt_pc(m_hpc), .cycle_count(m_cc)
  );

  cpu_run_monitor #(.TIMEOUT_CYCLES(50)) u_to (
    .clk(clk), .reset(reset), .run_en(run_t), .pc_i(pc),
    .dmem_raddr(t_raddr), .dmem_rdata(t_rdata),
    .out_valid(t_valid), .out_ready(out_ready), .out_data(t_data),
    .out_index(t_index), .out_last(t_last), .busy(t_busy), .done(t_done),
    .timed_out(t_to), .halt_pc(t_hpc), .cycle_count(t_cc)
  );

  cpu_run_monitor #(.STABLE_CYCLES(9), .TIMEOUT_CYCLES(10)) u_hz (
    .clk(clk), .reset(reset), .run_en(run_h), .pc_i(pc),
    .dmem_raddr(h_raddr), .dmem_rdata(h_rdata),
    .out_valid(h_valid), .out_ready(out_ready), .out_data(h_data),
    .out_index(h_index), .out_last(h_last), .busy(h_busy), .done(h_done),
    .timed_out(h_to), .halt_pc(h_hpc), .cycle_count(h_cc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic idle_main();
    @(negedge clk);
    run_m = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("idle_done", 32'(m_done), 32'd0);
  endtask

  // PC program: 0,4,..,100 then 104 forever; halt expected on RUN cycle 37.
  task automatic run_fib(input bit rnd, input int stall_idx);
    int          got = 0;
    bit          stalled = 1'b0;
    bit          stopped = 1'b0;
    logic [31:0] sd = '0;
    logic [7:0]  si = '0;
    logic        sl = 1'b0;
    @(negedge clk);
    pc = '0;
    run_m = 1'b1;
    out_ready = 1'b1;
    for (int k = 1; k < 600 && !m_done && !stopped; k++) begin
      @(negedge clk);
      pc = (k < 27) ? 32'(4 * (k - 1)) : 32'd104;
      if (stall_idx >= 0 && m_valid && m_index == 8'(stall_idx)) begin
        out_ready = 1'b0;
        stopped = 1'b1;
      end else begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (m_valid && stalled) begin
          check("hold_data", m_data, sd);
          check("hold_index", 32'(m_index), 32'(si));
          check("hold_last", 32'(m_last), 32'(sl));
        end
        stalled = m_valid && !out_ready;
        sd = m_data;
        si = m_index;
        sl = m_last;
        if (m_valid && out_ready) begin
          check("word_data", m_data, (got < 10) ? fib[got] : 32'hDEAD_BEEF);
          check("word_index", 32'(m_index), 32'(got));
          check("word_last", 32'(m_last), 32'(got == 9));
          got++;
        end
      end
    end
    if (!stopped) begin
      check("fib_done", 32'(m_done), 32'd1);
      check("fib_words", 32'(got), 32'd10);
      check("fib_halt_pc", m_hpc, 32'd104);
      check("fib_timed_out", 32'(m_to), 32'd0);
      check("fib_cycles", m_cc, 32'd37);
      check("fib_busy", 32'(m_busy), 32'd0);
    end
  endtask

  initial begin
    int got;
    fib = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21, 32'd34, 32'd55};
    for (int i = 0; i < 256; i++) begin
      if (i < 10) mem[i] = fib[i];
      else        mem[i] = 32'hA500_0000 | 32'(i);
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_busy", 32'(m_busy), 32'd0);
    check("rst_done", 32'(m_done), 32'd0);
    check("rst_raddr", 32'(m_raddr), 32'd0);
    check("rst_cycles", m_cc, 32'd0);
    reset = 1'b1;

    // Halt detection, full-rate dump
    idle_main();
    run_fib(1'b0, -1);

    // Same program with a randomly stalling consumer
    idle_main();
    run_fib(1'b1, -1);
    idle_main();

    // Timeout with an ever-incrementing PC
    @(negedge clk);
    pc = '0;
    run_t = 1'b1;
    out_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 400 && !t_done; k++) begin
      @(negedge clk);
      pc = pc + 32'd4;
      if (t_valid) begin
        check("to_data", t_data, (got < 10) ? fib[got] : 32'hDEAD_BEEF);
        check("to_index", 32'(t_index), 32'(got));
        got++;
      end
    end
    check("to_done", 32'(t_done), 32'd1);
    check("to_words", 32'(got), 32'd10);
    check("to_timed_out", 32'(t_to), 32'd1);
    check("to_halt_pc", t_hpc, 32'd0);
    check("to_cycles", t_cc, 32'd50);
    run_t = 1'b0;

    // Halt and timeout on the same RUN cycle
    @(negedge clk);
    pc = 32'h40;
    run_h = 1'b1;
    got = 0;
    for (int k = 0; k < 300 && !h_done; k++) begin
      @(negedge clk);
      if (h_valid) got++;
    end
    check("hz_done", 32'(h_done), 32'd1);
    check("hz_words", 32'(got), 32'd10);
    check("hz_timed_out", 32'(h_to), 32'd0);
    check("hz_halt_pc", h_hpc, 32'h40);
    check("hz_cycles", h_cc, 32'd10);
    run_h = 1'b0;

    // Reset while OUT is stalled on index 4, then a clean rerun
    run_fib(1'b0, 4);
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", 32'(m_valid), 32'd1);
      check("stall_index", 32'(m_index), 32'd4);
      check("stall_data", m_data, 32'd5);
    end
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_data", m_data, 32'd0);
    check("mid_rst_index", 32'(m_index), 32'd0);
    check("mid_rst_last", 32'(m_last), 32'd0);
    check("mid_rst_busy", 32'(m_busy), 32'd0);
    check("mid_rst_done", 32'(m_done), 32'd0);
    check("mid_rst_to", 32'(m_to), 32'd0);
    check("mid_rst_hpc", m_hpc, 32'd0);
    check("mid_rst_cycles", m_cc, 32'd0);
    check("mid_rst_raddr", 32'(m_raddr), 32'd0);
    reset = 1'b1;
    run_m = 1'b0;
    @(negedge clk);
    run_fib(1'b0, -1);

    // Abort from RUN, then a PC change at stable=9 restarting the count
    idle_main();
    @(negedge clk);
    pc = 32'h200;
    run_m = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_busy_pre", 32'(m_busy), 32'd1);
    run_m = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(m_busy), 32'd0);
    run_m = 1'b1;
    for (int k = 1; k < 300 && !m_done; k++) begin
      @(negedge clk);
      pc = (k <= 10) ? 32'h200 : 32'h300;
      if (k == 21) check("restart_cycles_20", m_cc, 32'd20);
      if (k == 23) check("restart_cycles_21", m_cc, 32'd21);
    end
    check("restart_done", 32'(m_done), 32'd1);
    check("restart_halt_pc", m_hpc, 32'h300);
    check("restart_timed_out", 32'(m_to), 32'd0);
    check("restart_cycles", m_cc, 32'd21);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
